// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO of bytes written by the register wrapper.
// A write is taken only on the rising edge of the write strobe; back-to-back frames have no idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_wr_i,
  input  logic [7:0]         uart_dat_i,
  output logic               uart_tx,
  output logic               uart_busy,
  output logic               tx_active,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned      DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               wr_prev_q;
  logic               tx_q, tx_d;
  logic               active_q, active_d;
  logic               busy_q;
  logic               baud_end_s, wr_edge_s, pop_s, push_s;

  assign baud_end_s = (baud_q == BAUD_LAST);
  assign wr_edge_s  = uart_wr_i & ~wr_prev_q;
  assign pop_s      = (count_q != {(FIFO_AW + 1){1'b0}}) &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end_s));
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign push_s     = wr_edge_s && ((count_q != DEPTH_C) || pop_s);
  assign count_d    = count_q + {{FIFO_AW{1'b0}}, push_s} - {{FIFO_AW{1'b0}}, pop_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d = S_START;
          baud_d  = 16'd0;
          shift_d = mem_q[rptr_q];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_d = S_DATA;
          baud_d  = 16'd0;
          idx_d   = 3'd0;
        end else begin
          baud_d  = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = 16'd0;
          if (pop_s) begin
            state_d = S_START;
            shift_d = mem_q[rptr_q];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
      end
    endcase
  end

  // Line level is decoded from the next state so the registered pin lines up with the state.
  always_comb begin
    tx_d     = 1'b1;
    active_d = 1'b0;
    case (state_d)
      S_IDLE:  begin tx_d = 1'b1;       active_d = 1'b0; end
      S_START: begin tx_d = 1'b0;       active_d = 1'b1; end
      S_DATA:  begin tx_d = shift_d[0]; active_d = 1'b1; end
      S_STOP:  begin tx_d = 1'b1;       active_d = 1'b1; end
      default: begin tx_d = 1'b1;       active_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      active_q  <= active_d;
      busy_q    <= (count_d == DEPTH_C);
      wr_prev_q <= uart_wr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wptr_q  <= {FIFO_AW{1'b0}};
      rptr_q  <= {FIFO_AW{1'b0}};
      count_q <= {(FIFO_AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= uart_dat_i;
        wptr_q        <= wptr_q + {{(FIFO_AW - 1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rptr_q <= rptr_q + {{(FIFO_AW - 1){1'b0}}, 1'b1};
      end
      count_q <= count_d;
    end
  end

  assign uart_tx    = tx_q;
  assign tx_active  = active_q;
  assign uart_busy  = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a fast-baud instance checked by a frame-decoding scoreboard monitor,
// and a full-rate instance used for the exact start-bit and frame-length timing.
module tb_uart_tx_fifo;

  localparam int CPB_A = 4;
  localparam int CPB_B = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_a = 1'b0, wr_b = 1'b0;
  logic [7:0] dat_a = 8'h00, dat_b = 8'h00;
  logic       tx_a, busy_a, act_a, tx_b, busy_b, act_b;
  logic [2:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_a = 0;
  int frames_started = 0;
  int act_cycles_a = 0;
  int act_rises_a = 0;
  logic act_prev_a = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .FIFO_AW(2)) dut_a (
    .clk(clk), .rst(rst), .uart_wr_i(wr_a), .uart_dat_i(dat_a),
    .uart_tx(tx_a), .uart_busy(busy_a), .tx_active(act_a), .fifo_count(cnt_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_AW(2)) dut_b (
    .clk(clk), .rst(rst), .uart_wr_i(wr_b), .uart_dat_i(dat_b),
    .uart_tx(tx_b), .uart_busy(busy_b), .tx_active(act_b), .fifo_count(cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (act_a) act_cycles_a <= act_cycles_a + 1;
    if (act_a && !act_prev_a) act_rises_a <= act_rises_a + 1;
    act_prev_a <= act_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // One-cycle write on instance A; e is the clock edge that samples the strobe.
  task automatic write_a(input logic [7:0] d, input bit accept, output int e);
    dat_a = d;
    wr_a  = 1'b1;
    step();
    e = cyc;
    if (accept) exp_q.push_back(d);
    wr_a = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || act_a) && n < 3000) begin
      step();
      n++;
    end
    check({name, "_drain"}, 32'(n < 3000), 32'd1);
    step();
  endtask

  // Scoreboard monitor: every frame on line A is checked cycle by cycle against the queued byte.
  initial begin
    logic [7:0] mb, rx;
    logic       eb;
    int         bad;
    bit         abort;
    forever begin
      @(negedge clk);
      if (!rst && tx_a === 1'b0) begin
        frames_started++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=frame required=none");
          mb = 8'h00;
        end else begin
          mb = exp_q.pop_front();
        end
        bad = 0;
        abort = 1'b0;
        rx = 8'h00;
        for (int i = 0; i < 10 * CPB_A; i++) begin
          if (i != 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (i < CPB_A) eb = 1'b0;
          else if (i >= 9 * CPB_A) eb = 1'b1;
          else eb = mb[(i - CPB_A) / CPB_A];
          if ((i >= CPB_A) && (i < 9 * CPB_A) && ((i % CPB_A) == CPB_A / 2))
            rx[(i - CPB_A) / CPB_A] = tx_a;
          if (tx_a !== eb || act_a !== 1'b1) bad++;
        end
        if (!abort) begin
          frames_a++;
          check($sformatf("frame_%02h_data", mb), 32'(rx), 32'(mb));
          check($sformatf("frame_%02h_shape", mb), 32'(bad), 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, d, f0, c0, r0, s0, bad, low_run;
    bit in_low, act_ok;
    logic [7:0] rxb;
    logic stopb;

    // Test 1: reset values, latency, single 0xA5 with strobe held for 3 cycles.
    #1;
    do_reset();
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_active", 32'(act_a), 32'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    f0 = frames_a; c0 = act_cycles_a; r0 = act_rises_a;
    dat_a = 8'hA5;
    wr_a  = 1'b1;
    step();
    exp_q.push_back(8'hA5);
    check("lat_count_n1", 32'(cnt_a), 32'd1);
    check("lat_tx_n1", 32'(tx_a), 32'd1);
    step();
    check("lat_start_tx", 32'(tx_a), 32'd0);
    check("lat_start_active", 32'(act_a), 32'd1);
    step();
    wr_a = 1'b0;
    drain("t1");
    check("t1_frames", 32'(frames_a - f0), 32'd1);
    check("t1_active_cycles", 32'(act_cycles_a - c0), 32'd40);
    check("t1_count_end", 32'(cnt_a), 32'd0);

    // Test 2: five writes fill the FIFO, a sixth is dropped; frames run back to back.
    f0 = frames_a; c0 = act_cycles_a; r0 = act_rises_a;
    for (int i = 1; i <= 5; i++) begin
      write_a(8'(i), 1'b1, e);
      if (i == 5) begin
        check("t2_busy_full", 32'(busy_a), 32'd1);
        check("t2_count_full", 32'(cnt_a), 32'd4);
      end
      step();
    end
    write_a(8'h06, 1'b0, e);
    check("t2_drop_count", 32'(cnt_a), 32'd4);
    check("t2_drop_busy", 32'(busy_a), 32'd1);
    drain("t2");
    check("t2_frames", 32'(frames_a - f0), 32'd5);
    check("t2_active_cycles", 32'(act_cycles_a - c0), 32'd200);
    check("t2_no_gap", 32'(act_rises_a - r0), 32'd1);

    // Test 3: write while full on the exact STOP->START pop edge.
    f0 = frames_a; c0 = act_cycles_a; r0 = act_rises_a;
    write_a(8'h10, 1'b1, e);
    for (int k = 1; k <= 4; k++) begin
      step();
      write_a(8'(8'h10 + k), 1'b1, d);
    end
    check("t3_count_full", 32'(cnt_a), 32'd4);
    while (cyc < e + 40) step();
    check("t3_count_pre", 32'(cnt_a), 32'd4);
    dat_a = 8'h15;
    wr_a  = 1'b1;
    step();
    exp_q.push_back(8'h15);
    wr_a = 1'b0;
    check("t3_pushpop_count", 32'(cnt_a), 32'd4);
    check("t3_pushpop_busy", 32'(busy_a), 32'd1);
    drain("t3");
    check("t3_frames", 32'(frames_a - f0), 32'd6);
    check("t3_active_cycles", 32'(act_cycles_a - c0), 32'd240);
    check("t3_no_gap", 32'(act_rises_a - r0), 32'd1);

    // Test 4: asynchronous reset during DATA bit 3 of 0x3C, then a clean 0x55.
    write_a(8'h3C, 1'b1, e);
    step();
    write_a(8'h77, 1'b1, d);
    step();
    write_a(8'h88, 1'b1, d);
    while (cyc < e + 18) step();
    check("t4_mid_active", 32'(act_a), 32'd1);
    check("t4_mid_count", 32'(cnt_a), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t4_async_tx", 32'(tx_a), 32'd1);
    check("t4_async_active", 32'(act_a), 32'd0);
    check("t4_async_count", 32'(cnt_a), 32'd0);
    check("t4_async_busy", 32'(busy_a), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    f0 = frames_a;
    write_a(8'h55, 1'b1, e);
    drain("t4");
    check("t4_frames", 32'(frames_a - f0), 32'd1);

    // Test 5: idle line for 1000 cycles after reset.
    do_reset();
    s0 = frames_started;
    bad = 0;
    repeat (1000) begin
      step();
      if (tx_a !== 1'b1 || act_a !== 1'b0) bad++;
    end
    check("t5_idle_bad", 32'(bad), 32'd0);
    check("t5_no_frame", 32'(frames_started - s0), 32'd0);

    // Test 6: full-rate instance, 0x0D, start bit and frame length timing.
    dat_b = 8'h0D;
    wr_b  = 1'b1;
    step();
    wr_b = 1'b0;
    step();
    check("t6_start_latency", 32'(tx_b), 32'd0);
    low_run = 0; in_low = 1'b1; rxb = 8'h00; stopb = 1'b0; act_ok = 1'b1;
    for (int n = 0; n < 10 * CPB_B; n++) begin
      if (in_low && tx_b === 1'b0) low_run++;
      else in_low = 1'b0;
      if ((n % CPB_B) == CPB_B / 2) begin
        if (n / CPB_B >= 1 && n / CPB_B <= 8) rxb[n / CPB_B - 1] = tx_b;
        if (n / CPB_B == 9) stopb = tx_b;
      end
      if (act_b !== 1'b1) act_ok = 1'b0;
      step();
    end
    check("t6_start_len", 32'(low_run), 32'd434);
    check("t6_data", 32'(rxb), 32'h0D);
    check("t6_stop_bit", 32'(stopb), 32'd1);
    check("t6_active_frame", 32'(act_ok), 32'd1);
    check("t6_end_active", 32'(act_b), 32'd0);
    check("t6_end_tx", 32'(tx_b), 32'd1);
    check("t6_count_end", 32'(cnt_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit engine for the J1 UART peripheral. It accepts byte writes from the peripheral register wrapper through a 4-entry FIFO and serialises each byte as 8N1 at a fixed baud rate. It drives the uart_tx pin and returns busy status to the wrapper's status register.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous active-high reset.
uart_wr_i  in  1  write strobe from wrapper (cs && wr); level signal, may stay high for several cycles.
uart_dat_i  in  8  byte to transmit; stable whenever uart_wr_i is high.
uart_tx  out  1  serial output, idle high.
uart_busy  out  1  high when FIFO is full; wrapper software polls it before writing.
tx_active  out  1  high while a frame (start..stop) is on the line.
fifo_count  out  FIFO_AW+1  number of bytes queued, excluding the byte being shifted.

Behaviour:
- Reset (async, any time, including mid-frame): uart_tx=1, uart_busy=0, tx_active=0, fifo_count=0, FSM=IDLE, baud counter=0, wr edge register=0. A partially sent frame is abandoned; the line returns high immediately.
- Write acceptance: a write is accepted only on the rising edge of uart_wr_i, i.e. when uart_wr_i=1 and it was 0 on the previous clk. uart_dat_i is captured in that same cycle. Holding uart_wr_i high enqueues exactly one byte.
- Write when FIFO is full (uart_busy=1): the byte is dropped. FIFO contents and pointers do not change. No error flag.
- FIFO: circular buffer with FIFO_AW-bit pointers plus count. Pointers wrap modulo depth.
  - uart_busy = (count == depth), registered from the count.
  - A simultaneous enqueue and dequeue in one cycle leaves count unchanged, and the enqueue succeeds even when full.
- FSM states:
  - IDLE: uart_tx=1, tx_active=0. If count>0, pop the head into the shift register, load the baud counter, go to START. First-byte latency: write edge at cycle N, FIFO holds the byte at N+1, START begins at N+2.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: uart_tx=shift[0], LSB first. After each CLKS_PER_BIT cycles, shift right and increment the index. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then, if count>0, pop and go directly to START with no extra idle cycle (back-to-back frames). Otherwise go to IDLE.
- tx_active=1 in START, DATA and STOP.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. It is 16 bits wide; its value is unobservable in IDLE.
- uart_tx is driven from a register, so the output is glitch-free.
- Frame length is exactly 10*CLKS_PER_BIT cycles.

Test Plan:
1. CLKS_PER_BIT=4. Reset, then a single write 0xA5 with wr held 3 cycles → one frame of 40 cycles: 0, then 1,0,1,0,0,1,0,1, then 1; fifo_count returns to 0; exactly one frame is sent.
2. Five back-to-back writes 0x01..0x05 (wr pulsed each 2 cycles) → the first is popped immediately. 0x02..0x05 fill the FIFO, so uart_busy=1 after the fifth write. A sixth write of 0x06 while busy is dropped. The line carries 0x01..0x05 in order with no idle gaps, for a total of 200 cycles of tx_active.
3. Enqueue while full, in the same cycle as STOP→START pops → count stays 4 and the byte is accepted. The frame sequence includes it.
4. Assert rst during DATA bit 3 of 0x3C → uart_tx=1 in the same cycle (async), FIFO is empty, busy=0. A subsequent write of 0x55 transmits cleanly.
5. Idle line check: after reset with no writes for 1000 cycles → uart_tx stays 1, tx_active stays 0, and there is no spurious frame.
6. CLKS_PER_BIT=434. Write 0x0D → the start bit is low for exactly 434 cycles, and the stop bit ends 4340 cycles after the start edge.
